// File: rtl/serial_pattern_matcher.sv
// Multi-pattern serial matcher: one shifted signal window compared against NPAT
// serially loaded patterns with per-bit don't-care masks and saturating hit counters.
module serial_pattern_matcher #(
   parameter  int WIDTH = 256,
   parameter  int NPAT  = 4,
   parameter  int CNT_W = 16,
   localparam int SEL_W = (NPAT > 1) ? $clog2(NPAT) : 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             sig,
   input  logic             sig_valid,
   input  logic             prgm,
   input  logic             prgm_mask,
   input  logic             prgm_valid,
   input  logic [SEL_W-1:0] prgm_sel,
   output logic             prgm_busy,
   output logic [NPAT-1:0]  armed,
   output logic [NPAT-1:0]  match,
   input  logic [SEL_W-1:0] hit_sel,
   input  logic             hit_clr,
   output logic [CNT_W-1:0] hit_count
);

   localparam int                FILL_W   = $clog2(WIDTH + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
   localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  load_idx_q, load_idx_d;
   logic [FILL_W-1:0] bit_cnt_q, bit_cnt_d;

   logic [WIDTH-1:0]  win_q, win_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [WIDTH-1:0]  pat_q  [NPAT];
   logic [WIDTH-1:0]  pat_d  [NPAT];
   logic [WIDTH-1:0]  mask_q [NPAT];
   logic [WIDTH-1:0]  mask_d [NPAT];
   logic [NPAT-1:0]   armed_q, armed_d;
   logic [NPAT-1:0]   match_q, match_d;
   logic [CNT_W-1:0]  cnt_q  [NPAT];
   logic [CNT_W-1:0]  cnt_d  [NPAT];

   logic [WIDTH-1:0]  next_win;
   logic              full_next;
   logic              sel_ok;

   // Window, fill tracking, match evaluation and hit counters.
   always_comb begin
      win_d     = win_q;
      fill_d    = fill_q;
      match_d   = '0;
      next_win  = {win_q[WIDTH-2:0], sig};
      full_next = (fill_q >= FILL_PRE);
      for (int i = 0; i < NPAT; i++) begin
         cnt_d[i] = cnt_q[i];
      end

      if (sig_valid) begin
         win_d = next_win;
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
         end
         // Pre-edge armed and pattern values are used, so a bit loaded at this
         // same edge cannot affect the match evaluated here.
         for (int i = 0; i < NPAT; i++) begin
            match_d[i] = armed_q[i] & full_next &
                         (((next_win ^ pat_q[i]) & ~mask_q[i]) == '0);
         end
      end

      for (int i = 0; i < NPAT; i++) begin
         if (hit_clr && (hit_sel == SEL_W'(i))) begin
            cnt_d[i] = '0;
         end else if (match_d[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Load FSM: next state, pattern/mask shifting and arming.
   always_comb begin
      state_d    = state_q;
      load_idx_d = load_idx_q;
      bit_cnt_d  = bit_cnt_q;
      armed_d    = armed_q;
      sel_ok     = (int'(prgm_sel) < NPAT);
      for (int i = 0; i < NPAT; i++) begin
         pat_d[i]  = pat_q[i];
         mask_d[i] = mask_q[i];
      end

      if (prgm_valid && sel_ok) begin
         for (int i = 0; i < NPAT; i++) begin
            if (prgm_sel == SEL_W'(i)) begin
               pat_d[i]  = {pat_q[i][WIDTH-2:0], prgm};
               mask_d[i] = {mask_q[i][WIDTH-2:0], prgm_mask};
            end
         end

         if ((state_q == LOAD) && (prgm_sel == load_idx_q)) begin
            if (bit_cnt_q == FILL_PRE) begin
               for (int i = 0; i < NPAT; i++) begin
                  if (load_idx_q == SEL_W'(i)) armed_d[i] = 1'b1;
               end
               state_d   = IDLE;
               bit_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + FILL_W'(1);
            end
         end else begin
            // First bit of a load, or a restart on another pattern; the
            // abandoned pattern keeps the disarm it received when its load began.
            state_d    = LOAD;
            load_idx_d = prgm_sel;
            bit_cnt_d  = FILL_W'(1);
            for (int i = 0; i < NPAT; i++) begin
               if (prgm_sel == SEL_W'(i)) armed_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q    <= IDLE;
         load_idx_q <= '0;
         bit_cnt_q  <= '0;
         win_q      <= '0;
         fill_q     <= '0;
         armed_q    <= '0;
         match_q    <= '0;
         for (int i = 0; i < NPAT; i++) begin
            pat_q[i]  <= '0;
            mask_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         load_idx_q <= load_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         win_q      <= win_d;
         fill_q     <= fill_d;
         armed_q    <= armed_d;
         match_q    <= match_d;
         for (int i = 0; i < NPAT; i++) begin
            pat_q[i]  <= pat_d[i];
            mask_q[i] <= mask_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   always_comb begin
      hit_count = '0;
      for (int i = 0; i < NPAT; i++) begin
         if (hit_sel == SEL_W'(i)) hit_count = cnt_q[i];
      end
   end

   assign prgm_busy = (state_q == LOAD);
   assign armed     = armed_q;
   assign match     = match_q;

endmodule

// File: tb/tb_serial_pattern_matcher.sv
// Bench for serial_pattern_matcher (WIDTH=8, NPAT=4, CNT_W=4): directed scenarios
// plus random traffic, all compared against a bit-history based reference model.
module tb_serial_pattern_matcher;

   localparam int WIDTH = 8;
   localparam int NPAT  = 4;
   localparam int CNT_W = 4;
   localparam int SEL_W = 2;

   logic             clk = 1'b0;
   logic             clr, sig, sig_valid, prgm, prgm_mask, prgm_valid, hit_clr;
   logic [SEL_W-1:0] prgm_sel, hit_sel;
   logic             prgm_busy;
   logic [NPAT-1:0]  armed, match;
   logic [CNT_W-1:0] hit_count;

   int n_checks = 0;
   int n_errors = 0;

   serial_pattern_matcher #(.WIDTH(WIDTH), .NPAT(NPAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .sig(sig), .sig_valid(sig_valid),
      .prgm(prgm), .prgm_mask(prgm_mask), .prgm_valid(prgm_valid),
      .prgm_sel(prgm_sel), .prgm_busy(prgm_busy), .armed(armed), .match(match),
      .hit_sel(hit_sel), .hit_clr(hit_clr), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   // Reference model: last WIDTH signal bits, count of bits since reset,
   // completed patterns, and the bits gathered so far for the load in progress.
   bit        m_hist[$];
   int        m_nsig;
   bit [7:0]  m_pat[NPAT];
   bit [7:0]  m_mask[NPAT];
   bit [3:0]  m_armed, m_match;
   int        m_cnt[NPAT];
   bit        m_loading;
   int        m_cur;
   bit        m_bits[$];
   bit        m_mbits[$];

   task automatic model_edge();
      bit [7:0] win, p, m;
      if (!clr) begin
         m_hist.delete(); m_bits.delete(); m_mbits.delete();
         m_nsig = 0; m_armed = '0; m_match = '0; m_loading = 1'b0; m_cur = 0;
         for (int i = 0; i < NPAT; i++) m_cnt[i] = 0;
      end else begin
         m_match = '0;
         if (sig_valid) begin
            m_hist.push_back(sig);
            if (m_hist.size() > WIDTH) void'(m_hist.pop_front());
            if (m_nsig < WIDTH) m_nsig++;
            if (m_nsig == WIDTH) begin
               win = '0;
               foreach (m_hist[k]) win = {win[6:0], m_hist[k]};
               for (int i = 0; i < NPAT; i++)
                  if (m_armed[i] && (((win ^ m_pat[i]) & ~m_mask[i]) == 8'h00)) m_match[i] = 1'b1;
            end
         end
         for (int i = 0; i < NPAT; i++) begin
            if (m_match[i] && m_cnt[i] < 15) m_cnt[i]++;
            if (hit_clr && hit_sel == i) m_cnt[i] = 0;
         end
         if (prgm_valid && prgm_sel < NPAT) begin
            if (!m_loading || prgm_sel != m_cur) begin
               m_loading = 1'b1; m_cur = prgm_sel;
               m_bits.delete(); m_mbits.delete();
            end
            m_armed[m_cur] = 1'b0;
            m_bits.push_back(prgm);
            m_mbits.push_back(prgm_mask);
            if (m_bits.size() == WIDTH) begin
               p = '0; m = '0;
               for (int k = 0; k < WIDTH; k++) begin
                  p = {p[6:0], m_bits[k]};
                  m = {m[6:0], m_mbits[k]};
               end
               m_pat[m_cur] = p; m_mask[m_cur] = m;
               m_armed[m_cur] = 1'b1; m_loading = 1'b0;
            end
         end
      end
   endtask

   function automatic logic [12:0] exp_vec();
      return {m_armed, m_match, m_loading, 4'(m_cnt[hit_sel])};
   endfunction

   // Drives one cycle at the falling edge, updates the model at the rising edge,
   // and returns at the next falling edge where outputs are sampled.
   task automatic step(bit c, bit sv, bit s, bit pv, bit pb, bit pm, int ps, int hs, bit hc);
      logic [1:0] ps2, hs2;
      ps2 = ps[1:0]; hs2 = hs[1:0];
      clr = c; sig_valid = sv; sig = s; prgm_valid = pv; prgm = pb; prgm_mask = pm;
      prgm_sel = ps2; hit_sel = hs2; hit_clr = hc;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 1, 1, 1, 0, 0);
      n_checks++;
      if ({armed, match, prgm_busy, hit_count} !== 13'h0) begin
         n_errors++;
         $display("FAIL reset_state: got %h exp %h", {armed, match, prgm_busy, hit_count}, 13'h0);
      end
      n_checks++;
      if ({armed, match, prgm_busy, hit_count} !== exp_vec()) begin
         n_errors++;
         $display("FAIL reset_model: got %h exp %h", {armed, match, prgm_busy, hit_count}, exp_vec());
      end
   endtask

   task automatic test_load_match();
      logic [7:0] v;
      v = 8'hA5;
      for (int b = 7; b >= 0; b--) begin
         step(1, 0, 0, 1, v[b], 0, 0, 0, 0);
         n_checks++;
         if ({armed, match, prgm_busy, hit_count} !== exp_vec()) begin
            n_errors++;
            $display("FAIL load0 bit %0d: got %h exp %h", b, {armed, match, prgm_busy, hit_count}, exp_vec());
         end
      end
      n_checks++;
      if (armed !== 4'b0001 || prgm_busy !== 1'b0) begin
         n_errors++;
         $display("FAIL load0_armed: got armed=%b busy=%b exp armed=0001 busy=0", armed, prgm_busy);
      end
      for (int b = 7; b >= 0; b--) begin
         step(1, 1, v[b], 0, 0, 0, 0, 0, 0);
         n_checks++;
         if ({armed, match, prgm_busy, hit_count} !== exp_vec()) begin
            n_errors++;
            $display("FAIL stream_a5 bit %0d: got %h exp %h", b, {armed, match, prgm_busy, hit_count}, exp_vec());
         end
      end
      n_checks++;
      if (match !== 4'b0001 || hit_count !== 4'd1) begin
         n_errors++;
         $display("FAIL match_a5: got match=%b cnt=%0d exp match=0001 cnt=1", match, hit_count);
      end
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (match !== 4'b0000 || hit_count !== 4'd1) begin
         n_errors++;
         $display("FAIL match_pulse: got match=%b cnt=%0d exp match=0000 cnt=1", match, hit_count);
      end
   endtask

   task automatic test_fill_guard();
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int b = 0; b < 8; b++) step(1, 0, 0, 1, 0, 0, 1, 1, 0);
      for (int k = 0; k < 12; k++) begin
         step(1, 1, 0, 0, 0, 0, 0, 1, 0);
         n_checks++;
         if ({armed, match, prgm_busy, hit_count} !== exp_vec() || match[1] !== (k >= 7)) begin
            n_errors++;
            $display("FAIL fill_guard zero %0d: got %h exp %h", k + 1, {armed, match, prgm_busy, hit_count}, exp_vec());
         end
      end
   endtask

   task automatic test_mask();
      logic [7:0] v, m;
      v = 8'hF0; m = 8'h0F;
      for (int b = 7; b >= 0; b--) step(1, 0, 0, 1, v[b], m[b], 2, 2, 0);
      for (int r = 0; r < 2; r++) begin
         v = (r == 0) ? 8'hF3 : 8'hE3;
         for (int b = 7; b >= 0; b--) begin
            step(1, 1, v[b], 0, 0, 0, 0, 2, 0);
            n_checks++;
            if ({armed, match, prgm_busy, hit_count} !== exp_vec()) begin
               n_errors++;
               $display("FAIL mask_stream %h bit %0d: got %h exp %h", v, b, {armed, match, prgm_busy, hit_count}, exp_vec());
            end
         end
         n_checks++;
         if (match[2] !== (r == 0)) begin
            n_errors++;
            $display("FAIL mask_window %h: got match2=%b exp %b", v, match[2], (r == 0));
         end
      end
   endtask

   task automatic test_interrupt();
      logic [7:0] a, c, d;
      a = 8'hA5; c = 8'h3C; d = 8'h5A;
      for (int b = 7; b >= 0; b--) step(1, 0, 0, 1, a[b], 0, 0, 0, 0);
      for (int b = 7; b >= 4; b--) step(1, 0, 0, 1, c[b], 0, 0, 0, 0);
      for (int b = 7; b >= 0; b--) begin
         step(1, 0, 0, 1, d[b], 0, 3, 3, 0);
         n_checks++;
         if ({armed, match, prgm_busy, hit_count} !== exp_vec()) begin
            n_errors++;
            $display("FAIL interrupt_load3 bit %0d: got %h exp %h", b, {armed, match, prgm_busy, hit_count}, exp_vec());
         end
      end
      n_checks++;
      if (armed[0] !== 1'b0 || armed[3] !== 1'b1 || prgm_busy !== 1'b0) begin
         n_errors++;
         $display("FAIL interrupt_state: got armed=%b busy=%b exp armed[0]=0 armed[3]=1 busy=0", armed, prgm_busy);
      end
      for (int b = 7; b >= 0; b--) step(1, 1, a[b], 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (match[0] !== 1'b0 || {armed, match, prgm_busy, hit_count} !== exp_vec()) begin
         n_errors++;
         $display("FAIL interrupt_nomatch: got %h exp %h", {armed, match, prgm_busy, hit_count}, exp_vec());
      end
   endtask

   task automatic test_saturation();
      for (int b = 0; b < 8; b++) step(1, 0, 0, 1, 0, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 20; k++) begin
         step(1, 1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 1, 0);
         n_checks++;
         if ({armed, match, prgm_busy, hit_count} !== exp_vec()) begin
            n_errors++;
            $display("FAIL saturate %0d: got %h exp %h", k, {armed, match, prgm_busy, hit_count}, exp_vec());
         end
      end
      n_checks++;
      if (hit_count !== 4'd15) begin
         n_errors++;
         $display("FAIL saturate_hold: got %0d exp 15", hit_count);
      end
      step(1, 1, 0, 0, 0, 0, 0, 1, 1);
      n_checks++;
      if (hit_count !== 4'd0 || match[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL clear_wins: got cnt=%0d match1=%b exp cnt=0 match1=1", hit_count, match[1]);
      end
      step(1, 1, 1, 0, 0, 0, 0, 1, 0);
      n_checks++;
      if (hit_count !== 4'd1) begin
         n_errors++;
         $display("FAIL count_after_clear: got %0d exp 1", hit_count);
      end
   endtask

   task automatic test_midreset();
      for (int b = 0; b < 3; b++) step(1, 0, 0, 1, 1, 0, 2, 0, 0);
      step(0, 0, 0, 1, 1, 0, 2, 0, 0);
      for (int h = 0; h < NPAT; h++) begin
         step(1, 0, 0, 0, 0, 0, 0, h, 0);
         n_checks++;
         if ({armed, match, prgm_busy, hit_count} !== 13'h0) begin
            n_errors++;
            $display("FAIL midreset_load sel %0d: got %h exp %h", h, {armed, match, prgm_busy, hit_count}, 13'h0);
         end
      end
      for (int b = 0; b < 8; b++) step(1, 0, 0, 1, 0, 1, 1, 1, 0);
      for (int k = 0; k < 5; k++) step(1, 1, 1, 0, 0, 0, 0, 1, 0);
      step(0, 1, 1, 0, 0, 0, 0, 1, 0);
      n_checks++;
      if ({armed, match, prgm_busy, hit_count} !== 13'h0) begin
         n_errors++;
         $display("FAIL midreset_stream: got %h exp %h", {armed, match, prgm_busy, hit_count}, 13'h0);
      end
      for (int b = 0; b < 8; b++) step(1, 0, 0, 1, 0, 1, 1, 1, 0);
      for (int k = 0; k < 8; k++) begin
         step(1, 1, 1, 0, 0, 0, 0, 1, 0);
         n_checks++;
         if (match[1] !== (k == 7) || {armed, match, prgm_busy, hit_count} !== exp_vec()) begin
            n_errors++;
            $display("FAIL refill %0d: got %h exp %h", k + 1, {armed, match, prgm_busy, hit_count}, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      int cur;
      cur = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 11) == 0) cur = $urandom_range(0, NPAT - 1);
         step(($urandom_range(0, 149) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              cur, $urandom_range(0, NPAT - 1), ($urandom_range(0, 9) == 0));
         n_checks++;
         if ({armed, match, prgm_busy, hit_count} !== exp_vec()) begin
            n_errors++;
            $display("FAIL random cycle %0d: got %h exp %h", k, {armed, match, prgm_busy, hit_count}, exp_vec());
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_load_match();
      test_fill_guard();
      test_mask();
      test_interrupt();
      test_saturation();
      test_midreset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
